fetch_ctrl: RTL and testbench

Fetch sequencer for the pipeline's byte-addressed, registered-output instruction memory (1-cycle read latency, synchronous flush-to-NOP input). It generates the fetch address and the memory's flush, and handles sequential fetch, stalls, taken-branch redirects, halt/resume and a post-reset boot bubble. It reports which PC the memory's instruction register currently holds and whether that word is valid. Fault detection is limited to misaligned or out-of-range redirects.

---
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency registered instruction memory:
// drives fetch address and flush, tracks the word held in the memory output register.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_BYTES   = 256,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] PC,
    output logic        flush,
    output logic        instr_valid,
    output logic [31:0] fetch_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [1:0]  state
);

    localparam int unsigned      CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [31:0]      LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [31:0]      npc;
    logic [31:0]      npc_nxt;
    logic [31:0]      seq_pc;
    logic [CNT_W-1:0] boot_cnt;
    logic [CNT_W-1:0] boot_cnt_nxt;
    logic             fault_nxt;
    logic [31:0]      fault_pc_nxt;
    logic             target_bad;

    assign target_bad = (redirect_target[1:0] != 2'b00) || (redirect_target > LAST_WORD);
    assign seq_pc     = (npc == LAST_WORD) ? 32'h0000_0000 : npc + 32'd4;
    assign state      = cur_state;

    // State and datapath registers; fetch_pc/instr_valid mirror the memory's own register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cur_state   <= S_BOOT;
            npc         <= RESET_PC;
            boot_cnt    <= '0;
            fault       <= 1'b0;
            fault_pc    <= 32'h0000_0000;
            fetch_pc    <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            npc         <= npc_nxt;
            boot_cnt    <= boot_cnt_nxt;
            fault       <= fault_nxt;
            fault_pc    <= fault_pc_nxt;
            fetch_pc    <= PC;
            instr_valid <= !flush;
        end
    end

    // Next state: redirect > halt_req > stall > sequential; FAULT is terminal
    always_comb begin
        nxt_state    = cur_state;
        npc_nxt      = npc;
        boot_cnt_nxt = boot_cnt;
        fault_nxt    = fault;
        fault_pc_nxt = fault_pc;

        if ((cur_state != S_FAULT) && redirect && target_bad) begin
            nxt_state    = S_FAULT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = redirect_target;
        end else begin
            case (cur_state)
                S_BOOT: begin
                    if (redirect) begin
                        npc_nxt = redirect_target;
                    end
                    if (boot_cnt == CNT_LAST) begin
                        nxt_state = S_RUN;
                    end else begin
                        boot_cnt_nxt = boot_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (redirect) begin
                        npc_nxt = redirect_target;
                    end else if (halt_req) begin
                        nxt_state = S_HALT;
                    end else if (!stall) begin
                        npc_nxt = seq_pc;
                    end
                end
                S_HALT: begin
                    if (redirect) begin
                        npc_nxt = redirect_target;
                    end else if (resume && !halt_req) begin
                        nxt_state = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory-side outputs; a held stall re-reads fetch_pc so the word stays put
    always_comb begin
        PC    = npc;
        flush = 1'b1;
        if ((cur_state == S_RUN) && stall && !redirect && !halt_req) begin
            PC = fetch_pc;
        end
        flush = (cur_state != S_RUN) || redirect ||
                ((cur_state == S_RUN) && (halt_req || (stall && !instr_valid)));
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic against a rule-level reference model with a memory model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0010;
    localparam int unsigned MEMB   = 256;
    localparam int unsigned BOOTC  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int ST_BOOT = 0, ST_RUN = 1, ST_HALT = 2, ST_FAULT = 3;

    logic        Clock = 1'b0;
    logic        nReset = 1'b1;
    logic        stall = 1'b0, redirect = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] PC, fetch_pc, fault_pc;
    logic        flush, instr_valid, fault;
    logic [1:0]  state;

    fetch_ctrl #(.RESET_PC(RST_PC), .MEM_BYTES(MEMB), .BOOT_CYCLES(BOOTC)) dut (
        .Clock(Clock), .nReset(nReset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
        .PC(PC), .flush(flush), .instr_valid(instr_valid), .fetch_pc(fetch_pc),
        .fault(fault), .fault_pc(fault_pc), .state(state)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    // Instruction memory: registered read with synchronous flush-to-NOP
    logic [31:0] mem_q;
    always_ff @(posedge Clock) mem_q <= flush ? NOP : word_at(PC);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(ST_BOOT));
        chk({tag, ".pc"}, PC, RST_PC);
        chk({tag, ".flush"}, 32'(flush), 32'd1);
        chk({tag, ".fetch_pc"}, fetch_pc, RST_PC);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".fault"}, 32'(fault), 32'd0);
        chk({tag, ".fault_pc"}, fault_pc, 32'd0);
    endtask

    // ---------------- reference model ----------------
    int          m_st;
    int          m_boot_seen;
    logic [31:0] m_npc, m_fpc, m_fault_pc;
    bit          m_iv, m_fault;

    task automatic model_reset();
        m_st = ST_BOOT; m_boot_seen = 0; m_npc = RST_PC; m_fpc = RST_PC;
        m_fault_pc = 32'h0; m_iv = 1'b0; m_fault = 1'b0;
    endtask

    function automatic logic [31:0] model_pc(input bit s, input bit r, input bit h);
        return (m_st == ST_RUN && s && !r && !h) ? m_fpc : m_npc;
    endfunction

    function automatic bit model_flush(input bit s, input bit r, input bit h);
        return (m_st != ST_RUN) || r || (m_st == ST_RUN && (h || (s && !m_iv)));
    endfunction

    task automatic model_step(input bit s, input bit r, input logic [31:0] t,
                              input bit h, input bit rs,
                              input logic [31:0] pc_now, input bit flush_now);
        bit legal;
        legal = (t % 4 == 0) && (t <= MEMB - 4);
        m_fpc = pc_now;
        m_iv  = !flush_now;
        if (m_st == ST_FAULT) return;
        if (r && !legal) begin
            m_st = ST_FAULT; m_fault = 1'b1; m_fault_pc = t;
            return;
        end
        if (r) m_npc = t;
        if (m_st == ST_BOOT) begin
            m_boot_seen++;
            if (m_boot_seen == BOOTC) m_st = ST_RUN;
        end else if (!r) begin
            if (m_st == ST_RUN) begin
                if (h) m_st = ST_HALT;
                else if (!s) m_npc = (m_npc + 32'd4) % MEMB;
            end else if (rs && !h) begin
                m_st = ST_RUN;
            end
        end
    endtask

    // One model-checked cycle; entered and left at a negedge
    task automatic mcycle(input bit s, input bit r, input logic [31:0] t, input bit h, input bit rs);
        logic [31:0] epc;
        bit          efl;
        stall = s; redirect = r; redirect_target = t; halt_req = h; resume = rs;
        #1;
        epc = model_pc(s, r, h);
        efl = model_flush(s, r, h);
        chk("m.pc", PC, epc);
        chk("m.flush", 32'(flush), 32'(efl));
        @(posedge Clock);
        model_step(s, r, t, h, rs, epc, efl);
        #1;
        chk("m.state", 32'(state), 32'(m_st));
        chk("m.fetch_pc", fetch_pc, m_fpc);
        chk("m.valid", 32'(instr_valid), 32'(m_iv));
        chk("m.fault", 32'(fault), 32'(m_fault));
        chk("m.fault_pc", fault_pc, m_fault_pc);
        chk("m.mem_word", mem_q, m_iv ? word_at(m_fpc) : NOP);
        @(negedge Clock);
    endtask

    // Asynchronous reset pulse between edges; returns at a negedge with reset released
    task automatic reset_dut(input string tag);
        nReset = 1'b0;
        #1;
        chk_reset_values(tag);
        model_reset();
        @(negedge Clock);
        stall = 0; redirect = 0; redirect_target = 0; halt_req = 0; resume = 0;
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        s, r;
        logic [31:0] t;
        logic        h, rs;
        logic        e_flush;
        logic [31:0] e_fpc;
        logic        e_iv;
        logic [1:0]  e_st;
        logic        e_fault;
        logic [31:0] e_fault_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic h, input logic rs, input logic fl,
                                input logic [31:0] fpc, input logic iv, input logic [1:0] st,
                                input logic f, input logic [31:0] fp);
        vec_t v;
        v.s = s; v.r = r; v.t = t; v.h = h; v.rs = rs; v.e_flush = fl;
        v.e_fpc = fpc; v.e_iv = iv; v.e_st = st; v.e_fault = f; v.e_fault_pc = fp;
        return v;
    endfunction

    vec_t vt [0:40];

    initial begin
        // s  r  target h rs | flush fetch_pc valid state fault fault_pc
        vt[0]  = mk(0,0,32'h00,0,0, 1,32'h10,0,0,0,0);
        vt[1]  = mk(0,0,32'h00,0,0, 1,32'h10,0,1,0,0);
        vt[2]  = mk(0,0,32'h00,0,0, 0,32'h10,1,1,0,0);
        vt[3]  = mk(0,0,32'h00,0,0, 0,32'h14,1,1,0,0);
        vt[4]  = mk(0,0,32'h00,0,0, 0,32'h18,1,1,0,0);
        vt[5]  = mk(0,1,32'h08,0,0, 1,32'h1C,0,1,0,0);
        vt[6]  = mk(0,0,32'h00,0,0, 0,32'h08,1,1,0,0);
        vt[7]  = mk(1,0,32'h00,0,0, 0,32'h08,1,1,0,0);
        vt[8]  = mk(1,0,32'h00,0,0, 0,32'h08,1,1,0,0);
        vt[9]  = mk(1,0,32'h00,0,0, 0,32'h08,1,1,0,0);
        vt[10] = mk(0,0,32'h00,0,0, 0,32'h0C,1,1,0,0);
        vt[11] = mk(0,1,32'h20,0,0, 1,32'h10,0,1,0,0);
        vt[12] = mk(0,0,32'h00,0,0, 0,32'h20,1,1,0,0);
        vt[13] = mk(0,1,32'h40,0,0, 1,32'h24,0,1,0,0);
        vt[14] = mk(0,0,32'h00,0,0, 0,32'h40,1,1,0,0);
        vt[15] = mk(1,1,32'h40,1,0, 1,32'h44,0,1,0,0);
        vt[16] = mk(1,0,32'h00,0,0, 1,32'h44,0,1,0,0);
        vt[17] = mk(1,0,32'h00,0,0, 1,32'h44,0,1,0,0);
        vt[18] = mk(0,0,32'h00,0,0, 0,32'h40,1,1,0,0);
        vt[19] = mk(0,1,32'h30,0,0, 1,32'h44,0,1,0,0);
        vt[20] = mk(0,0,32'h00,0,0, 0,32'h30,1,1,0,0);
        vt[21] = mk(0,0,32'h00,0,0, 0,32'h34,1,1,0,0);
        vt[22] = mk(0,0,32'h00,1,0, 1,32'h38,0,2,0,0);
        vt[23] = mk(0,0,32'h00,1,1, 1,32'h38,0,2,0,0);
        vt[24] = mk(0,0,32'h00,0,1, 1,32'h38,0,1,0,0);
        vt[25] = mk(0,0,32'h00,0,0, 0,32'h38,1,1,0,0);
        vt[26] = mk(0,0,32'h00,1,0, 1,32'h3C,0,2,0,0);
        vt[27] = mk(0,1,32'h80,0,0, 1,32'h3C,0,2,0,0);
        vt[28] = mk(0,0,32'h00,0,1, 1,32'h80,0,1,0,0);
        vt[29] = mk(0,0,32'h00,0,0, 0,32'h80,1,1,0,0);
        vt[30] = mk(0,1,32'hF8,0,0, 1,32'h84,0,1,0,0);
        vt[31] = mk(0,0,32'h00,0,0, 0,32'hF8,1,1,0,0);
        vt[32] = mk(0,0,32'h00,0,0, 0,32'hFC,1,1,0,0);
        vt[33] = mk(0,0,32'h00,0,0, 0,32'h00,1,1,0,0);
        vt[34] = mk(0,0,32'h00,0,0, 0,32'h04,1,1,0,0);
        vt[35] = mk(0,1,32'hFC,0,0, 1,32'h08,0,1,0,0);
        vt[36] = mk(0,0,32'h00,0,0, 0,32'hFC,1,1,0,0);
        vt[37] = mk(0,0,32'h00,0,0, 0,32'h00,1,1,0,0);
        vt[38] = mk(0,1,32'h42,0,0, 1,32'h04,0,3,1,32'h42);
        vt[39] = mk(0,1,32'h40,0,1, 1,32'h04,0,3,1,32'h42);
        vt[40] = mk(0,0,32'h00,0,0, 1,32'h04,0,3,1,32'h42);

        // Reset before any clock edge
        #2 nReset = 1'b0;
        #1 chk_reset_values("por");
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;

        for (int i = 0; i < 41; i++) begin
            stall = vt[i].s; redirect = vt[i].r; redirect_target = vt[i].t;
            halt_req = vt[i].h; resume = vt[i].rs;
            #1;
            chk($sformatf("v%0d.flush", i), 32'(flush), 32'(vt[i].e_flush));
            chk($sformatf("v%0d.pc", i), PC, vt[i].e_fpc);
            @(posedge Clock);
            #1;
            chk($sformatf("v%0d.fetch_pc", i), fetch_pc, vt[i].e_fpc);
            chk($sformatf("v%0d.valid", i), 32'(instr_valid), 32'(vt[i].e_iv));
            chk($sformatf("v%0d.state", i), 32'(state), 32'(vt[i].e_st));
            chk($sformatf("v%0d.fault", i), 32'(fault), 32'(vt[i].e_fault));
            chk($sformatf("v%0d.fault_pc", i), fault_pc, vt[i].e_fault_pc);
            chk($sformatf("v%0d.mem_word", i), mem_q, vt[i].e_iv ? word_at(vt[i].e_fpc) : NOP);
            @(negedge Clock);
        end

        // Async reset while in FAULT with a redirect pending
        redirect = 1'b1; redirect_target = 32'h40;
        #2;
        reset_dut("rst_in_fault");

        // Out-of-range redirect faults
        for (int i = 0; i < 3; i++) mcycle(0, 0, 0, 0, 0);
        mcycle(0, 1, 32'h100, 0, 0);
        chk("oob.state", 32'(state), 32'(ST_FAULT));
        chk("oob.fault_pc", fault_pc, 32'h100);
        mcycle(0, 0, 0, 0, 1);

        // Async reset mid-HALT; also a redirect during BOOT
        #2;
        reset_dut("rst_pre_halt");
        mcycle(0, 1, 32'h60, 0, 0);
        mcycle(0, 0, 0, 0, 0);
        mcycle(0, 0, 0, 0, 0);
        chk("boot_redirect.fetch_pc", fetch_pc, 32'h60);
        mcycle(0, 0, 0, 1, 0);
        #2;
        reset_dut("rst_in_halt");

        // Randomized traffic against the reference model
        begin
            int fault_cycles = 0;
            for (int n = 0; n < 3000; n++) begin
                bit s, r, h, rs;
                logic [31:0] t;
                s  = ($urandom_range(0, 4) == 0);
                r  = ($urandom_range(0, 9) == 0);
                h  = ($urandom_range(0, 19) == 0);
                rs = ($urandom_range(0, 4) == 0);
                case ($urandom_range(0, 19))
                    0:       t = 32'($urandom_range(0, MEMB - 1)) | 32'd1;
                    1:       t = 32'(MEMB) + 32'($urandom_range(0, 255)) * 32'd4;
                    2:       t = 32'(MEMB - 4);
                    default: t = 32'($urandom_range(0, MEMB / 4 - 1)) * 32'd4;
                endcase
                mcycle(s, r, t, h, rs);
                fault_cycles = (m_st == ST_FAULT) ? fault_cycles + 1 : 0;
                if (fault_cycles > 4 || $urandom_range(0, 299) == 0) begin
                    #($urandom_range(1, 3));
                    reset_dut("rand_rst");
                    fault_cycles = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
